// File: rtl/carregador_programa.sv
// -----------------------------------------------------------------------------
// carregador_programa
// Streams a program into instruction memory ahead of the datapath.
// Stream layout: 16-bit word count N (MSB first), N big-endian 32-bit words,
// then one checksum byte equal to the XOR of every preceding byte of the load.
// Each assembled word goes out as a single-cycle write to ADDR_BASE+index.
// On a good checksum the datapath is released from reset.
//
// Ports
//   _clock       system clock, rising edge
//   _reset       asynchronous active-high reset
//   _iniciar     start pulse (honoured in ESPERA, PRONTO, ERRO)
//   _byte_in     stream byte
//   _byte_valid  _byte_in valid
//   _byte_ready  loader accepts a byte this cycle
//   _mem_addr    write address
//   _mem_data    write data
//   _mem_we      one-cycle write strobe
//   _palavras    words written in the current load
//   _pronto      load finished with good checksum
//   _erro        load failed (bad count or bad checksum)
//   _cpu_reset   datapath hold-in-reset, low only in PRONTO
// -----------------------------------------------------------------------------
module carregador_programa #(
    parameter logic [31:0] ADDR_BASE = 32'd0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        _clock,
    input  logic        _reset,
    input  logic        _iniciar,
    input  logic [7:0]  _byte_in,
    input  logic        _byte_valid,
    output logic        _byte_ready,
    output logic [31:0] _mem_addr,
    output logic [31:0] _mem_data,
    output logic        _mem_we,
    output logic [15:0] _palavras,
    output logic        _pronto,
    output logic        _erro,
    output logic        _cpu_reset
);

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        CONT_H  = 3'd1,
        CONT_L  = 3'd2,
        DADO    = 3'd3,
        ESCRITA = 3'd4,
        CHECK   = 3'd5,
        PRONTO  = 3'd6,
        ERRO    = 3'd7
    } estado_t;

    estado_t     estado_r, estado_s;
    logic [15:0] cont_r, cont_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [23:0] asm_r, asm_s;
    logic [7:0]  acc_r, acc_s;
    logic [15:0] palavras_r, palavras_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_data_r, mem_data_s;
    logic        byte_ready_r, mem_we_r, pronto_r, erro_r, cpu_reset_r;
    logic        xfer_s, iniciar_aceito_s;

    // Legal word count: 1..MAX_WORDS.
    function automatic logic contagem_valida(input logic [15:0] n);
        contagem_valida = (n != 16'd0) && ({16'd0, n} <= MAX_WORDS[31:0]);
    endfunction

    // States in which the byte link is open.
    function automatic logic aceita_byte(input estado_t e);
        case (e)
            CONT_H, CONT_L, DADO, CHECK: aceita_byte = 1'b1;
            default:                     aceita_byte = 1'b0;
        endcase
    endfunction

    // The registered ready always mirrors the current state, so it is the
    // handshake qualifier directly.
    assign xfer_s           = byte_ready_r & _byte_valid;
    assign iniciar_aceito_s = _iniciar &&
                              ((estado_r == ESPERA) || (estado_r == PRONTO) || (estado_r == ERRO));

    // State register.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            estado_r <= ESPERA;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            ESPERA, PRONTO, ERRO: begin
                if (_iniciar) estado_s = CONT_H;
                else          estado_s = estado_r;
            end
            CONT_H: begin
                if (xfer_s) estado_s = CONT_L;
                else        estado_s = CONT_H;
            end
            CONT_L: begin
                if (xfer_s) begin
                    if (contagem_valida({cont_r[15:8], _byte_in})) estado_s = DADO;
                    else                                          estado_s = ERRO;
                end else begin
                    estado_s = CONT_L;
                end
            end
            DADO: begin
                if (xfer_s && (byte_idx_r == 2'd3)) estado_s = ESCRITA;
                else                                estado_s = DADO;
            end
            ESCRITA: begin
                if (({1'b0, palavras_r} + 17'd1) == {1'b0, cont_r}) estado_s = CHECK;
                else                                                 estado_s = DADO;
            end
            CHECK: begin
                if (xfer_s) begin
                    if (_byte_in == acc_r) estado_s = PRONTO;
                    else                   estado_s = ERRO;
                end else begin
                    estado_s = CHECK;
                end
            end
            default: estado_s = ESPERA;
        endcase
    end

    // Datapath next values: count, assembly, checksum, word counter, write bus.
    always_comb begin
        cont_s     = cont_r;
        byte_idx_s = byte_idx_r;
        asm_s      = asm_r;
        acc_s      = acc_r;
        palavras_s = palavras_r;
        mem_addr_s = mem_addr_r;
        mem_data_s = mem_data_r;
        if (iniciar_aceito_s) begin
            byte_idx_s = 2'd0;
            asm_s      = 24'd0;
            acc_s      = 8'd0;
            palavras_s = 16'd0;
        end else if (xfer_s) begin
            // The checksum byte itself never enters the accumulator.
            if (estado_r != CHECK) acc_s = acc_r ^ _byte_in;
            else                   acc_s = acc_r;
            case (estado_r)
                CONT_H: cont_s[15:8] = _byte_in;
                CONT_L: cont_s[7:0]  = _byte_in;
                DADO: begin
                    asm_s      = {asm_r[15:0], _byte_in};
                    byte_idx_s = byte_idx_r + 2'd1;
                    // Bus is loaded now so it is valid throughout ESCRITA.
                    if (byte_idx_r == 2'd3) begin
                        mem_data_s = {asm_r, _byte_in};
                        mem_addr_s = ADDR_BASE + {16'd0, palavras_r};
                    end else begin
                        mem_data_s = mem_data_r;
                        mem_addr_s = mem_addr_r;
                    end
                end
                default: cont_s = cont_r;
            endcase
        end else if (estado_r == ESCRITA) begin
            palavras_s = palavras_r + 16'd1;
        end else begin
            palavras_s = palavras_r;
        end
    end

    // Registered datapath and state-decoded outputs.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            cont_r       <= 16'd0;
            byte_idx_r   <= 2'd0;
            asm_r        <= 24'd0;
            acc_r        <= 8'd0;
            palavras_r   <= 16'd0;
            mem_addr_r   <= 32'd0;
            mem_data_r   <= 32'd0;
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            pronto_r     <= 1'b0;
            erro_r       <= 1'b0;
            cpu_reset_r  <= 1'b1;
        end else begin
            cont_r       <= cont_s;
            byte_idx_r   <= byte_idx_s;
            asm_r        <= asm_s;
            acc_r        <= acc_s;
            palavras_r   <= palavras_s;
            mem_addr_r   <= mem_addr_s;
            mem_data_r   <= mem_data_s;
            byte_ready_r <= aceita_byte(estado_s);
            mem_we_r     <= (estado_s == ESCRITA);
            pronto_r     <= (estado_s == PRONTO);
            erro_r       <= (estado_s == ERRO);
            cpu_reset_r  <= (estado_s != PRONTO);
        end
    end

    assign _byte_ready = byte_ready_r;
    assign _mem_addr   = mem_addr_r;
    assign _mem_data   = mem_data_r;
    assign _mem_we     = mem_we_r;
    assign _palavras   = palavras_r;
    assign _pronto     = pronto_r;
    assign _erro       = erro_r;
    assign _cpu_reset  = cpu_reset_r;

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader that streams a calculator program into instruction memory before the datapath runs. It accepts bytes over a valid/ready interface, assembles big-endian 32-bit instruction words and writes them to consecutive memory addresses with single-cycle write pulses. It then checks a trailing XOR checksum and releases the processor. It sits between the host byte link and the write port of `Memoria`, and drives the datapath's hold-in-reset line.

## Interface
- `ADDR_BASE`, 0: memory address of the first loaded word.
- `MAX_WORDS`, 256: largest legal word count; valid range 1..65535.
- `_clock`  in  1  single system clock; all logic on the rising edge.
- `_reset`  in  1  asynchronous, active-high reset.
- `_iniciar`  in  1  start pulse; sampled only in ESPERA, PRONTO and ERRO.
- `_byte_in`  in  8  stream byte.
- `_byte_valid`  in  1  `_byte_in` is valid.
- `_byte_ready`  out  1  loader can accept a byte; a transfer happens when valid and ready are both high on a rising edge.
- `_mem_addr`  out  32  write address.
- `_mem_data`  out  32  write data.
- `_mem_we`  out  1  one-cycle write strobe.
- `_palavras`  out  16  number of words written in the current load.
- `_pronto`  out  1  load finished with a good checksum; stays high until restart or reset.
- `_erro`  out  1  load failed; stays high until restart or reset.
- `_cpu_reset`  out  1  holds the datapath in reset; high in every state except PRONTO.

## Operation
- States: ESPERA, CONT_H, CONT_L, DADO, ESCRITA, CHECK, PRONTO, ERRO.
- Stream format:
  - count N: 16 bits, high byte first.
  - N words: 4 bytes each, MSB first.
  - 1 checksum byte: XOR of every preceding byte in the load, count bytes included.
- ESPERA (reset state): `_byte_ready`=0. On `_iniciar`=1, go to CONT_H and clear `_palavras`, word index, byte index and the XOR accumulator.
- CONT_H: on transfer, latch N[15:8] and go to CONT_L.
- CONT_L: on transfer, latch N[7:0], then branch:
  - N==0 or N>MAX_WORDS → ERRO.
  - otherwise → DADO.
- DADO: on transfer, shift the byte into the assembly register and increment the byte index (0..3). On the 4th byte, go to ESCRITA.
- ESCRITA: drive `_mem_we`=1, `_mem_addr`=ADDR_BASE+index (32-bit, wraps modulo 2^32), `_mem_data`=assembled word. Increment the word index and `_palavras`, then:
  - index reaches N → CHECK.
  - otherwise → DADO.
- CHECK: on transfer, compare the byte against the accumulator:
  - equal → PRONTO.
  - different → ERRO.
- Every accepted byte, except the checksum byte itself, is XORed into the accumulator.
- PRONTO: `_pronto`=1, `_cpu_reset`=0.
- ERRO: `_erro`=1, `_cpu_reset`=1.
- From PRONTO or ERRO, `_iniciar` → CONT_H with `_pronto`, `_erro` and `_palavras` cleared and `_cpu_reset` reasserted in that same edge.
- `_iniciar` is ignored in CONT_H, CONT_L, DADO, ESCRITA and CHECK.
- Words already written are never rolled back on error.

## Timing
- Reset values: `_byte_ready`=0, `_mem_we`=0, `_mem_addr`=0, `_mem_data`=0, `_palavras`=0, `_pronto`=0, `_erro`=0, `_cpu_reset`=1, state ESPERA.
- Reset asserted mid-load aborts immediately and discards any partial word. It takes effect without waiting for a clock edge.
- All outputs are registered, and `_byte_ready` is a pure function of state:
  - high in CONT_H, CONT_L, DADO, CHECK.
  - low in ESPERA, ESCRITA, PRONTO, ERRO.
- `_mem_we` rises the cycle after the 4th byte of a word is accepted and lasts exactly 1 cycle. `_byte_ready` is 0 during that cycle.
- Peak throughput is 4 bytes per 5 cycles.
- `_mem_addr` and `_mem_data` hold their last values outside ESCRITA.
- Gaps with `_byte_valid`=0 stall the machine in its current state with no side effects.
- `_pronto` or `_erro` rises 1 cycle after the checksum byte transfer. The ERRO entry from CONT_L occurs 1 cycle after the low count byte.
- `_palavras` updates at the end of the ESCRITA cycle.

## Test plan
- Reset, pulse `_iniciar`, stream 00 01 12 34 56 78 09 → one `_mem_we` pulse with addr 0, data 0x12345678; `_pronto`=1, `_cpu_reset`=0, `_palavras`=1.
- Same stream with checksum 0x0A → the write still occurs; `_erro`=1, `_pronto`=0, `_cpu_reset`=1.
- N=3 with `_byte_valid` toggled randomly → exactly 3 writes at addresses 0,1,2 with correct data; `_byte_ready` is 0 in each write cycle; `_pronto`=1.
- Count bytes 00 00, and separately 01 01 with MAX_WORDS=256 → `_erro`=1 one cycle after the second count byte and no `_mem_we` pulse.
- Assert `_reset` after 2 data bytes of word 0 → all outputs return to reset values immediately. A fresh `_iniciar` plus a full good stream then loads correctly.
- After PRONTO, pulse `_iniciar` → `_pronto`=0, `_cpu_reset`=1, `_palavras`=0 the next cycle. A second good load with ADDR_BASE=0x40 writes starting at 0x40.
